// File: rtl/spram16x64_arb_ctrl_pkg.sv
// Shared types and constants for the 16x64 single-port SRAM arbiter.
// Holds the controller state encoding and the macro geometry.
package spram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RAM_DW    = 64;
    localparam int RAM_AW    = 4;
    localparam int RAM_DEPTH = 16;

endpackage

// File: rtl/spram16x64_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer.
// The pointer moves past the winner on every grant and holds otherwise.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [GW-1:0] gidx
);

    logic [GW-1:0] ptr_q;
    logic [GW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = GW'((int'(ptr_q) + k) % N);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/spram16x64_arb_ctrl.sv
// Zero-fills a 16x64 SPRAM after reset, then arbitrates it among requesters.
// Define SPRAM16X64_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module spram16x64_arb_ctrl
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = RAM_DW,
    parameter int AW      = RAM_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  init_done,
    output logic                  ram_ceb,
    output logic                  ram_web,
    output logic [AW-1:0]         ram_a,
    output logic [DW-1:0]         ram_d,
    input  logic [DW-1:0]         ram_q
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q;
    logic          arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [GW-1:0] gidx;
    logic          rd_pend_q;
    logic [GW-1:0] rd_idx_q;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && &cnt_q) begin
            state_d = ST_RUN;
        end
    end

    assign arb_en = !rst && (state_q == ST_RUN);

`ifdef SPRAM16X64_ARB_FIXED_PRIO_EN
    logic found;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_en && !found && req_valid[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gidx   = GW'(i);
            end
        end
    end
`else
    rr_arbiter #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req   (req_valid),
        .grant (gnt),
        .gidx  (gidx)
    );
`endif

    // RAM pins are combinational; the wrapper samples them at the next edge.
    always_comb begin
        ram_ceb   = 1'b1;
        ram_web   = 1'b1;
        ram_a     = '0;
        ram_d     = '0;
        init_done = 1'b0;
        req_ready = '0;
        if (!rst) begin
            case (state_q)
                ST_INIT: begin
                    ram_ceb = 1'b0;
                    ram_web = 1'b0;
                    ram_a   = cnt_q;
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    req_ready = gnt;
                    if (|gnt) begin
                        ram_ceb = 1'b0;
                        ram_web = ~req_we[gidx];
                        ram_a   = req_addr[int'(gidx)*AW +: AW];
                        ram_d   = req_wdata[int'(gidx)*DW +: DW];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= (|gnt) && !req_we[gidx];
            if (|gnt) begin
                rd_idx_q <= gidx;
            end
            if (rd_pend_q) begin
                rdata_q <= ram_q;
            end
        end
    end

    // Read data passes straight from the macro; rdata_q only keeps it stable.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (!rst) begin
            rsp_rdata = rd_pend_q ? ram_q : rdata_q;
            if (rd_pend_q) begin
                rsp_valid[rd_idx_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spram16x64_arb_ctrl.sv
// Self-checking bench: directed table, multi-cycle sequences, and a
// randomized run against an array-based reference of the arbitrated SRAM.
module tb_spram16x64_arb_ctrl;

    localparam logic [63:0] D0 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_we;
    logic [7:0]   req_addr;
    logic [127:0] req_wdata;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_rdata;
    logic         init_done;
    logic         ram_ceb;
    logic         ram_web;
    logic [3:0]   ram_a;
    logic [63:0]  ram_d;
    logic [63:0]  ram_q;

    logic [63:0]  sram [16];

    int checks = 0;
    int errors = 0;

    spram16x64_arb_ctrl #(
        .NUM_REQ (2),
        .DW      (64),
        .AW      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .ram_ceb   (ram_ceb),
        .ram_web   (ram_web),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM wrapper: registers pins at the edge, read data one cycle later.
    always @(posedge clk) begin
        if (!ram_ceb) begin
            if (!ram_web) sram[ram_a] <= ram_d;
            else          ram_q <= sram[ram_a];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  rdy;
        logic [1:0]  rsp;
        logic [63:0] rdata;
    } vec_t;

    vec_t tbl [14];

    logic [1:0]  rv, rwe;
    logic [3:0]  ra [2];
    logic [63:0] rd [2];
    logic [63:0] mem_m [16];
    int          rr_m;
    bit          pend;
    int          pend_idx;
    logic [63:0] pend_data;
    int          g;
    logic [1:0]  exp2;

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = {$urandom, $urandom};

        tbl[0]  = '{2'b01, 2'b01, 4'd5,  4'd0, D0, 64'h0, 2'b01, 2'b00, 64'h0};
        tbl[1]  = '{2'b01, 2'b00, 4'd5,  4'd0, 64'h0, 64'h0, 2'b01, 2'b00, 64'h0};
        tbl[2]  = '{2'b00, 2'b00, 4'd0,  4'd0, 64'h0, 64'h0, 2'b00, 2'b01, D0};
        tbl[3]  = '{2'b01, 2'b00, 4'd15, 4'd0, 64'h0, 64'h0, 2'b01, 2'b00, D0};
        tbl[4]  = '{2'b10, 2'b10, 4'd0,  4'd1, 64'h0, D1, 2'b10, 2'b01, 64'h0};
        tbl[5]  = '{2'b01, 2'b01, 4'd2,  4'd0, D2, 64'h0, 2'b01, 2'b00, 64'h0};
        tbl[6]  = '{2'b10, 2'b00, 4'd0,  4'd3, 64'h0, 64'h0, 2'b10, 2'b00, 64'h0};
`ifdef SPRAM16X64_ARB_FIXED_PRIO_EN
        tbl[7]  = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b01, 2'b10, 64'h0};
        tbl[8]  = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b01, 2'b01, D1};
        tbl[9]  = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b01, 2'b01, D1};
        tbl[10] = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b01, 2'b01, D1};
        tbl[11] = '{2'b00, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 2'b00, 2'b01, D1};
        tbl[12] = '{2'b10, 2'b00, 4'd0, 4'd2, 64'h0, 64'h0, 2'b10, 2'b00, D1};
`else
        tbl[7]  = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b01, 2'b10, 64'h0};
        tbl[8]  = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b10, 2'b01, D1};
        tbl[9]  = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b01, 2'b10, D2};
        tbl[10] = '{2'b11, 2'b00, 4'd1, 4'd2, 64'h0, 64'h0, 2'b10, 2'b01, D1};
        tbl[11] = '{2'b00, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 2'b00, 2'b10, D2};
        tbl[12] = '{2'b10, 2'b00, 4'd0, 4'd2, 64'h0, 64'h0, 2'b10, 2'b00, D2};
`endif
        tbl[13] = '{2'b00, 2'b00, 4'd0, 4'd0, 64'h0, 64'h0, 2'b00, 2'b10, D2};

        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_ceb", ram_ceb, 1);
            chk("rst_web", ram_web, 1);
            chk("rst_ready", req_ready, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rdata", rsp_rdata, 0);
        end

        // Zero-fill with a read from req0 stalled behind it.
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {4'd9, 4'd7};
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_ceb", ram_ceb, 0);
            chk("fill_web", ram_web, 0);
            chk("fill_a", ram_a, i);
            chk("fill_d", ram_d, 0);
            chk("fill_stall_ready", req_ready, 0);
            chk("fill_init_done", init_done, 0);
            @(negedge clk); #1;
        end
        chk("init_done_rise", init_done, 1);
        chk("stalled_grant", req_ready, 2'b01);
        chk("stalled_web", ram_web, 1);
        chk("stalled_a", ram_a, 7);

        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("req1_grant", req_ready, 2'b10);
        chk("stalled_rsp", rsp_valid, 2'b01);
        chk("stalled_rdata", rsp_rdata, 0);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("req1_rsp", rsp_valid, 2'b10);
        chk("req1_rdata", rsp_rdata, 0);

        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            req_valid = tbl[r].v;
            req_we    = tbl[r].we;
            req_addr  = {tbl[r].a1, tbl[r].a0};
            req_wdata = {tbl[r].d1, tbl[r].d0};
            #1;
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
            chk($sformatf("tbl%0d_rsp_valid", r), rsp_valid, tbl[r].rsp);
            chk($sformatf("tbl%0d_rdata", r), rsp_rdata, tbl[r].rdata);
            chk($sformatf("tbl%0d_ceb", r), ram_ceb, tbl[r].rdy == 2'b00);
        end

        // Reset lands in the cycle after a read grant.
        @(negedge clk);
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {4'd0, 4'd5};
        #1;
        chk("mid_rd_grant", req_ready, 2'b01);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("mid_rd_rsp_rst", rsp_valid, 0);
        chk("mid_rd_ceb_rst", ram_ceb, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rd_rsp_after", rsp_valid, 0);
        for (int i = 0; i < 16; i++) begin
            chk("refill_ceb", ram_ceb, 0);
            chk("refill_a", ram_a, i);
            @(negedge clk); #1;
        end
        chk("refill_done", init_done, 1);

        // Randomized traffic against an array reference.
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        rr_m = 0;
        pend = 0;
        pend_idx = 0;
        pend_data = '0;
        rv = '0;
        rwe = '0;
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            req_valid = rv;
            req_we    = rwe;
            req_addr  = {ra[1], ra[0]};
            req_wdata = {rd[1], rd[0]};
            #1;
            g = -1;
            for (int k = 0; k < 2; k++) begin
`ifdef SPRAM16X64_ARB_FIXED_PRIO_EN
                if (g < 0 && rv[k]) g = k;
`else
                if (g < 0 && rv[(rr_m + k) % 2]) g = (rr_m + k) % 2;
`endif
            end
            exp2 = (g < 0) ? 2'b00 : (2'b01 << g);
            chk("rnd_ready", req_ready, exp2);
            exp2 = pend ? (2'b01 << pend_idx) : 2'b00;
            chk("rnd_rsp_valid", rsp_valid, exp2);
            if (pend) chk("rnd_rdata", rsp_rdata, pend_data);
            pend = 0;
            if (g >= 0) begin
                if (rwe[g]) begin
                    mem_m[ra[g]] = rd[g];
                end else begin
                    pend      = 1;
                    pend_idx  = g;
                    pend_data = mem_m[ra[g]];
                end
                rr_m  = (g + 1) % 2;
                rv[g] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && $urandom_range(0, 3) != 0) begin
                    rv[i]  = 1'b1;
                    rwe[i] = ($urandom_range(0, 2) == 0);
                    ra[i]  = 4'($urandom_range(0, 7));
                    rd[i]  = {$urandom, $urandom};
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
